// File: rtl/pixel_feeder_pkg.sv
// Shared state type and default constants for the pixel feeder and its buffer.
package pixel_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam int DEF_IMG_WIDTH  = 4;
    localparam int DEF_IMG_HEIGHT = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DIV        = 4;
    localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/pixel_feeder_if.sv
// Upstream pixel handshake plus the paced pixel stream toward the display controller.
// Defining PIXEL_FEEDER_UNDERRUN_CNT_EN adds the underrun_cnt signal.
interface pixel_feeder_if
    import pixel_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  pix_tick;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  frame_done;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    logic [15:0]           underrun_cnt;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, pix_tick, pix_data, pix_valid, frame_done, underrun_cnt
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, pix_tick, pix_data, pix_valid, frame_done, underrun_cnt
    );
`else
    modport master (
        output start, in_valid, in_data,
        input  in_ready, pix_tick, pix_data, pix_valid, frame_done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, pix_tick, pix_data, pix_valid, frame_done
    );
`endif
endinterface

// File: rtl/pixel_feeder_fifo.sv
// Single-clock pixel buffer with first-word-fall-through head (rd_data is valid whenever !empty).
module pixel_fifo
    import pixel_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // The extra pointer bit tells a full buffer apart from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_feeder.sv
// Buffers upstream pixels and releases one per pix_tick (every DIV clocks) for a whole frame.
// Defining PIXEL_FEEDER_UNDERRUN_CNT_EN adds a saturating underrun tick counter.
module pixel_feeder
    import pixel_feeder_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIV        = DEF_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    pixel_feeder_if.slave  bus
);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int DIV_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      in_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [DATA_WIDTH-1:0] head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  tick_now;
    logic                  start_ok;

    pixel_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.in_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // start only matters outside STREAM; a restart from DONE also clears the frame counters.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = STREAM;
                    start_ok   = 1'b1;
                end
            end
            STREAM: begin
                if (out_cnt == TOTAL_C) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next = STREAM;
                    start_ok   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready   = !fifo_full && (in_cnt < TOTAL_C) && (state != DONE);
    assign bus.frame_done = (state == DONE);
    assign push           = bus.in_valid && bus.in_ready;
    assign tick_now       = (state == STREAM) && (div_cnt == DIV_LAST);
    assign pop            = tick_now && !fifo_empty;

    // Outputs are registered on the tick edge so the popped head lines up with pix_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            div_cnt       <= '0;
            in_cnt        <= '0;
            out_cnt       <= '0;
            bus.pix_tick  <= 1'b0;
            bus.pix_data  <= '0;
            bus.pix_valid <= 1'b0;
        end else begin
            state        <= state_next;
            div_cnt      <= ((state == STREAM) && (div_cnt != DIV_LAST)) ? div_cnt + 1'b1 : '0;
            bus.pix_tick <= tick_now;
            if (tick_now) begin
                bus.pix_data  <= pop ? head : '0;
                bus.pix_valid <= pop;
            end
            if (start_ok && (state == DONE)) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (push) begin
                    in_cnt <= in_cnt + 1'b1;
                end
                if (pop) begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            bus.underrun_cnt <= '0;
        end else if (tick_now && fifo_empty && (bus.underrun_cnt != 16'hFFFF)) begin
            bus.underrun_cnt <= bus.underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_feeder.sv
// Self-checking bench: two feeders (16-deep and 4-deep buffer) share stimulus and are
// compared every cycle against a frame-level model; directed scenarios pin literal values.
module tb_pixel_feeder;
    localparam int TOTAL = 8;
    localparam int DIV   = 4;
    localparam int SRC_N = 1024;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid  [2];
    logic [7:0] in_data   [2];
    logic       out_ready [2];
    logic       out_tick  [2];
    logic [7:0] out_data  [2];
    logic       out_valid [2];
    logic       out_done  [2];
    logic [15:0] out_under [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pixel_feeder_if #(.DATA_WIDTH(8)) bus0 ();
    pixel_feeder_if #(.DATA_WIDTH(8)) bus1 ();

    pixel_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .DATA_WIDTH(8), .DIV(DIV), .FIFO_DEPTH(16)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    pixel_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .DATA_WIDTH(8), .DIV(DIV), .FIFO_DEPTH(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    assign bus0.start    = start;
    assign bus0.in_valid = in_valid[0];
    assign bus0.in_data  = in_data[0];
    assign bus1.start    = start;
    assign bus1.in_valid = in_valid[1];
    assign bus1.in_data  = in_data[1];

    assign out_ready[0] = bus0.in_ready;
    assign out_tick[0]  = bus0.pix_tick;
    assign out_data[0]  = bus0.pix_data;
    assign out_valid[0] = bus0.pix_valid;
    assign out_done[0]  = bus0.frame_done;
    assign out_ready[1] = bus1.in_ready;
    assign out_tick[1]  = bus1.pix_tick;
    assign out_data[1]  = bus1.pix_data;
    assign out_valid[1] = bus1.pix_valid;
    assign out_done[1]  = bus1.frame_done;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    assign out_under[0] = bus0.underrun_cnt;
    assign out_under[1] = bus1.underrun_cnt;
`else
    assign out_under[0] = 16'h0;
    assign out_under[1] = 16'h0;
`endif

    // Frame-level model: a queue-like buffer, pixel counts, and a tick every DIV
    // cycles measured from the cycle streaming began.
    int         cyc  = 0;
    bit         live = 1'b0;
    logic [7:0] m_buf [2][64];
    int         m_rd [2];
    int         m_wr [2];
    int         m_cnt [2];
    int         m_in [2];
    int         m_out [2];
    int         m_under [2];
    int         m_start [2];
    bit         m_stream [2];
    bit         m_done [2];
    bit         m_tick [2];
    bit         m_valid [2];
    bit         m_acc [2];
    logic [7:0] m_data [2];

    // Stimulus source shared by both feeders; each consumes it at its own pace.
    logic [7:0] src [SRC_N];
    int         src_len = 0;
    int         src_pos [2];
    int         feed_hold = 0;
    bit         rand_valid = 1'b0;

    // Observation log of dut0 used by the literal checks.
    int         t_n = 0;
    int         t_cyc [64];
    logic [7:0] t_data [64];
    logic       t_valid [64];
    int         done_cyc = -1;
    int         acc_cnt [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic bit model_ready(input int i);
        return (m_cnt[i] < depth_of(i)) && (m_in[i] < TOTAL) && !m_done[i];
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input int i);
        bit rdy;
        bit tk;
        bit was_stream;
        bit was_done;
        int out_before;
        if (reset) begin
            m_rd[i] = 0; m_wr[i] = 0; m_cnt[i] = 0; m_in[i] = 0; m_out[i] = 0;
            m_under[i] = 0; m_start[i] = 0; m_stream[i] = 1'b0; m_done[i] = 1'b0;
            m_tick[i] = 1'b0; m_valid[i] = 1'b0; m_data[i] = 8'h00; m_acc[i] = 1'b0;
            live = 1'b1;
        end else begin
            rdy        = model_ready(i);
            was_stream = m_stream[i];
            was_done   = m_done[i];
            out_before = m_out[i];
            m_acc[i]   = in_valid[i] && rdy;
            tk         = was_stream && (((cyc - m_start[i]) % DIV) == 0);
            m_tick[i]  = tk;
            if (tk) begin
                if (m_cnt[i] > 0) begin
                    m_data[i]  = m_buf[i][m_rd[i]];
                    m_rd[i]    = (m_rd[i] + 1) % 64;
                    m_cnt[i]   = m_cnt[i] - 1;
                    m_valid[i] = 1'b1;
                    m_out[i]   = m_out[i] + 1;
                end else begin
                    m_data[i]  = 8'h00;
                    m_valid[i] = 1'b0;
                    if (m_under[i] < 65535) m_under[i] = m_under[i] + 1;
                end
            end
            if (m_acc[i]) begin
                m_buf[i][m_wr[i]] = in_data[i];
                m_wr[i]  = (m_wr[i] + 1) % 64;
                m_cnt[i] = m_cnt[i] + 1;
                m_in[i]  = m_in[i] + 1;
            end
            if (was_stream && (out_before == TOTAL)) begin
                m_stream[i] = 1'b0;
                m_done[i]   = 1'b1;
            end else if (!was_stream && start) begin
                if (was_done) begin
                    m_in[i]  = 0;
                    m_out[i] = 0;
                end
                m_stream[i] = 1'b1;
                m_done[i]   = 1'b0;
                m_start[i]  = cyc;
                m_under[i]  = 0;
            end
        end
    endtask

    // Advance the model on every rising edge using the inputs the DUTs just sampled.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) model_edge(i);
    end

    // Compare both DUTs against the model on the falling edge, and log dut0 activity.
    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("dut%0d.in_ready", i), int'(out_ready[i]), int'(model_ready(i)));
                checkOutput($sformatf("dut%0d.pix_tick", i), int'(out_tick[i]), int'(m_tick[i]));
                checkOutput($sformatf("dut%0d.pix_data", i), int'(out_data[i]), int'(m_data[i]));
                checkOutput($sformatf("dut%0d.pix_valid", i), int'(out_valid[i]), int'(m_valid[i]));
                checkOutput($sformatf("dut%0d.frame_done", i), int'(out_done[i]), int'(m_done[i]));
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
                checkOutput($sformatf("dut%0d.underrun_cnt", i), int'(out_under[i]), m_under[i]);
`endif
                if (in_valid[i] && out_ready[i] && !reset) acc_cnt[i]++;
            end
            if (out_tick[0] && (t_n < 64)) begin
                t_cyc[t_n]   = cyc;
                t_data[t_n]  = out_data[0];
                t_valid[t_n] = out_valid[0];
                t_n++;
            end
            if (out_done[0] && (done_cyc < 0)) done_cyc = cyc;
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (feed_hold > 0) feed_hold--;
        for (int i = 0; i < 2; i++) begin
            if (m_acc[i]) src_pos[i]++;
            in_valid[i] = (feed_hold == 0) && (src_pos[i] < src_len) &&
                          (!rand_valid || ($urandom_range(0, 3) != 0));
            in_data[i]  = (src_pos[i] < src_len) ? src[src_pos[i]] : 8'h00;
        end
    endtask

    task automatic clearLog();
        t_n = 0;
        done_cyc = -1;
        for (int k = 0; k < 64; k++) begin
            t_cyc[k] = 0; t_data[k] = 8'h00; t_valid[k] = 1'b0;
        end
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
    endtask

    task automatic loadPixels(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) src[k] = base + 8'(k);
        src_len = n;
        src_pos[0] = 0;
        src_pos[1] = 0;
    endtask

    task automatic doReset();
        reset = 1'b1; start = 1'b0; src_len = 0; feed_hold = 0; rand_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            src_pos[i] = 0; in_valid[i] = 1'b0; in_data[i] = 8'h00;
        end
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        applyStimulus();
    endtask

    task automatic pulseStart(output int st);
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        st = cyc;
    endtask

    initial begin
        int st;
        int guard;
        int nv;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = 8'h00; src_pos[i] = 0; acc_cnt[i] = 0;
        end

        // Reset values, then prefill 8 pixels in IDLE and stream them.
        doReset();
        checkOutput("reset.in_ready", int'(out_ready[0]), 1);
        checkOutput("reset.pix_tick", int'(out_tick[0]), 0);
        checkOutput("reset.pix_data", int'(out_data[0]), 0);
        checkOutput("reset.pix_valid", int'(out_valid[0]), 0);
        checkOutput("reset.frame_done", int'(out_done[0]), 0);
        clearLog();
        loadPixels(8'h10, 8);
        repeat (12) applyStimulus();
        checkOutput("prefill.pushes", acc_cnt[0], 8);
        checkOutput("backpressure.pushes", acc_cnt[1], 4);
        checkOutput("backpressure.in_ready", int'(out_ready[1]), 0);
        pulseStart(st);
        repeat (45) applyStimulus();
        checkOutput("prefill.tick_count", t_n, 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("prefill.tick%0d_offset", k), t_cyc[k] - st, 4 * (k + 1));
            checkOutput($sformatf("prefill.tick%0d_data", k), int'(t_data[k]), 16 + k);
            checkOutput($sformatf("prefill.tick%0d_valid", k), int'(t_valid[k]), 1);
        end
        checkOutput("prefill.done_after_last_tick", done_cyc - t_cyc[7], 1);
        checkOutput("backpressure.frame_done", int'(out_done[1]), 1);

        // Frame limit: the 9th offered pixel waits until a start in DONE.
        doReset();
        clearLog();
        loadPixels(8'h20, 9);
        repeat (12) applyStimulus();
        checkOutput("limit.pushes_idle", acc_cnt[0], 8);
        checkOutput("limit.in_ready_after_8", int'(out_ready[0]), 0);
        pulseStart(st);
        repeat (40) applyStimulus();
        checkOutput("limit.frame_done", int'(out_done[0]), 1);
        checkOutput("limit.in_ready_in_done", int'(out_ready[0]), 0);
        checkOutput("limit.pushes_in_done", acc_cnt[0], 8);
        pulseStart(st);
        repeat (3) applyStimulus();
        checkOutput("limit.pushes_after_restart", acc_cnt[0], 9);
        checkOutput("limit.done_cleared", int'(out_done[0]), 0);

        // Underrun: start with nothing buffered, first pixel arrives about 10 clocks later.
        doReset();
        clearLog();
        loadPixels(8'h30, 8);
        feed_hold = 11;
        pulseStart(st);
        repeat (60) applyStimulus();
        checkOutput("underrun.tick0_valid", int'(t_valid[0]), 0);
        checkOutput("underrun.tick0_data", int'(t_data[0]), 0);
        checkOutput("underrun.tick1_valid", int'(t_valid[1]), 0);
        checkOutput("underrun.tick1_data", int'(t_data[1]), 0);
        checkOutput("underrun.tick2_data", int'(t_data[2]), 8'h30);
        nv = 0;
        for (int k = 0; k < t_n; k++) nv += int'(t_valid[k]);
        checkOutput("underrun.valid_ticks", nv, 8);
        checkOutput("underrun.frame_done", int'(out_done[0]), 1);
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
        checkOutput("underrun.count", int'(out_under[0]), 2);
`endif

        // Reset after three emitted pixels, then a fresh frame must not see stale data.
        doReset();
        clearLog();
        loadPixels(8'h40, 8);
        repeat (9) applyStimulus();
        pulseStart(st);
        guard = 0;
        while ((t_n < 3) && (guard < 100)) begin
            applyStimulus();
            guard++;
        end
        checkOutput("midreset.pixels_before_reset", t_n, 3);
        reset = 1'b1;
        applyStimulus();
        checkOutput("midreset.pix_tick", int'(out_tick[0]), 0);
        checkOutput("midreset.pix_data", int'(out_data[0]), 0);
        checkOutput("midreset.pix_valid", int'(out_valid[0]), 0);
        checkOutput("midreset.frame_done", int'(out_done[0]), 0);
        checkOutput("midreset.in_ready", int'(out_ready[0]), 1);
        reset = 1'b0;
        src_len = 0;
        clearLog();
        loadPixels(8'h50, 8);
        repeat (10) applyStimulus();
        checkOutput("midreset.refill_pushes", acc_cnt[0], 8);
        pulseStart(st);
        repeat (40) applyStimulus();
        checkOutput("midreset.tick_count", t_n, 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("midreset.tick%0d_data", k), int'(t_data[k]), 8'h50 + k);
        end

        // A second start while streaming must not disturb timing or order.
        doReset();
        clearLog();
        loadPixels(8'h60, 8);
        repeat (9) applyStimulus();
        pulseStart(st);
        repeat (5) applyStimulus();
        begin
            int st2;
            pulseStart(st2);
        end
        repeat (40) applyStimulus();
        checkOutput("restart.tick_count", t_n, 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("restart.tick%0d_offset", k), t_cyc[k] - st, 4 * (k + 1));
            checkOutput($sformatf("restart.tick%0d_data", k), int'(t_data[k]), 8'h60 + k);
        end

        // Random traffic: gappy valid, random data, random starts and occasional resets.
        doReset();
        for (int k = 0; k < SRC_N; k++) src[k] = 8'($urandom);
        src_len = SRC_N;
        src_pos[0] = 0;
        src_pos[1] = 0;
        rand_valid = 1'b1;
        for (int n = 0; n < 800; n++) begin
            start = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 249) == 0);
            applyStimulus();
        end
        start = 1'b0;
        reset = 1'b0;
        rand_valid = 1'b0;
        repeat (4) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 4, meaning pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 2, meaning lines per frame; TOTAL = IMG_WIDTH*IMG_HEIGHT.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per pixel.
REQ-004 The block SHALL have parameter DIV, default 4, meaning system clocks per pixel tick; legal range 2..255.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 16, meaning pixel buffer entries; power of two.
REQ-006 clk  in  1  system clock; single clock domain, all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle strobe that begins streaming a frame.
REQ-009 in_valid  in  1  upstream pixel valid.
REQ-010 in_data  in  DATA_WIDTH  upstream pixel value.
REQ-011 in_ready  out  1  block accepts in_data this cycle.
REQ-012 pix_tick  out  1  one-cycle pixel-rate strobe toward the display controller.
REQ-013 pix_data  out  DATA_WIDTH  current pixel, held between ticks.
REQ-014 pix_valid  out  1  pix_data is a real pixel (0 on underrun).
REQ-015 frame_done  out  1  level, all TOTAL pixels emitted.
REQ-016 underrun_cnt  out  16  underrun tick count; present only with the macro in REQ-034.

Function
REQ-017 The block SHALL implement states IDLE, STREAM and DONE.
REQ-018 The block SHALL transition IDLE->STREAM on start; it SHALL ignore start in STREAM.
REQ-019 The block SHALL, on start in DONE, clear in_cnt, out_cnt and frame_done and enter STREAM.
REQ-020 The block SHALL transfer a pixel on in_valid && in_ready and push it into the FIFO; prefill in IDLE is allowed.
REQ-021 The block SHALL assert in_ready = !fifo_full && (in_cnt < TOTAL) && state != DONE.
REQ-022 The block SHALL stop accepting pixels once in_cnt reaches TOTAL; excess upstream data stalls until the next start.
REQ-023 The block SHALL run a divider 0..DIV-1 only in STREAM, reset it to 0 on entry to STREAM, and assert pix_tick for one cycle when it equals DIV-1.
REQ-024 The block SHALL register pix_data, pix_valid and pix_tick in the same cycle, so that the popped pixel appears with its tick.
REQ-025 On a tick with a non-empty FIFO, the block SHALL pop, drive pix_data = head, set pix_valid = 1 and increment out_cnt.
REQ-026 On a tick with an empty FIFO (underrun), the block SHALL drive pix_data = 0 and pix_valid = 0, and leave out_cnt unchanged.
REQ-027 The block SHALL leave the FIFO count unchanged on a simultaneous push and pop; a push when full is impossible by REQ-021.
REQ-028 When out_cnt reaches TOTAL, the block SHALL enter DONE on the next cycle and assert frame_done from that cycle until reset or start.
REQ-029 In DONE, the block SHALL hold pix_tick = 0 and keep pix_data at its last value.
REQ-030 The block SHALL size in_cnt and out_cnt as $clog2(TOTAL+1) bits; they SHALL never wrap.

Reset
REQ-031 On reset, the block SHALL set state = IDLE and empty the FIFO.
REQ-032 On reset, the block SHALL clear the divider, in_cnt, out_cnt and underrun_cnt.
REQ-033 On reset, the block SHALL clear pix_tick, pix_data, pix_valid and frame_done; reset mid-frame discards buffered pixels, and in_ready is 1 in the cycle after reset deasserts.

Configuration
REQ-034 With PIXEL_FEEDER_UNDERRUN_CNT_EN defined, the block SHALL provide underrun_cnt, which increments on each underrun tick, saturates at 16'hFFFF and clears on reset or start.
REQ-035 Without PIXEL_FEEDER_UNDERRUN_CNT_EN, the block SHALL have neither the underrun_cnt port nor its counter; all other behaviour is identical.

Structure
REQ-036 Package pixel_feeder_pkg SHALL hold the state typedef (IDLE, STREAM, DONE) and default constants for DATA_WIDTH, DIV and FIFO_DEPTH.
REQ-037 The buffer SHALL be one sub-module, pixel_fifo: a synchronous single-clock FIFO with full, empty, push and pop, and first-word-fall-through head.

Verification
REQ-038 The bench SHALL cover prefill and stream: push 8 pixels 0x10..0x17 in IDLE, then start -> pix_tick every 4 clks, pix_data 0x10..0x17 with pix_valid = 1, frame_done high the cycle after the 8th tick.
REQ-039 The bench SHALL cover backpressure: in_valid held high with FIFO_DEPTH = 4 and no start -> in_ready drops after 4 pushes, no data lost after start.
REQ-040 The bench SHALL cover underrun: start with empty FIFO, first pixel arrives after 10 clks -> ticks 1-2 have pix_valid = 0 and pix_data = 0, underrun_cnt = 2 (macro on), frame still ends after 8 valid pixels.
REQ-041 The bench SHALL cover the frame limit: upstream offers 9 pixels -> in_ready is 0 after the 8th; the 9th is accepted only after a start in DONE.
REQ-042 The bench SHALL cover reset mid-frame: reset after 3 emitted pixels -> next cycle all outputs 0, state IDLE, FIFO empty; a new frame then runs correctly.
REQ-043 The bench SHALL cover start in STREAM: a second start during streaming -> no divider restart, pixel sequence and timing unchanged.
